// File: rtl/prefetch_fetch_unit.sv
// prefetch_fetch_unit: instruction prefetcher feeding ID from a circular {pc, instr} queue.
// Ports: CLK/RESET; IMEM_ADDR/IMEM_READ/IMEM_RDATA/IMEM_BUSYWAIT memory side;
//        REDIRECT/REDIRECT_PC from EX; STALL from ID; IF_VALID/IF_PC/IF_INSTR/OCCUPANCY queue head.
// Latency: a completed fetch is visible at the head one cycle later; the queue never overflows (IMEM_READ drops when full).
module prefetch_fetch_unit #(
  parameter int              XLEN      = 32,
  parameter int              DEPTH     = 4,
  parameter logic [XLEN-1:0] RESET_PC  = 32'h00000000,
  parameter logic [31:0]     NOP_INSTR = 32'h00000013
) (
  input  logic                     CLK,
  input  logic                     RESET,
  output logic [XLEN-1:0]          IMEM_ADDR,
  output logic                     IMEM_READ,
  input  logic [31:0]              IMEM_RDATA,
  input  logic                     IMEM_BUSYWAIT,
  input  logic                     REDIRECT,
  input  logic [XLEN-1:0]          REDIRECT_PC,
  input  logic                     STALL,
  output logic                     IF_VALID,
  output logic [XLEN-1:0]          IF_PC,
  output logic [31:0]              IF_INSTR,
  output logic [$clog2(DEPTH):0]   OCCUPANCY
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {ST_RUN, ST_DISCARD} state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0]   discard_pc_q, discard_pc_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic [XLEN-1:0]   pc_mem_q    [DEPTH];
  logic [31:0]       instr_mem_q [DEPTH];

  logic full;
  logic xfer_done;
  logic xfer_pending;
  logic push;
  logic pop;

  // Target low bits are ignored: fetch addresses are always word aligned.
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^REDIRECT_PC[1:0];

  always_comb begin
    full         = (count_q == CNT_W'(DEPTH));
    // DISCARD must keep the abandoned request alive until memory finishes it.
    // Gating with RESET drops the request the instant reset asserts.
    IMEM_READ    = !RESET && ((state_q == ST_DISCARD) || !full);
    IMEM_ADDR    = (state_q == ST_DISCARD) ? discard_pc_q : fetch_pc_q;
    xfer_done    = IMEM_READ && !IMEM_BUSYWAIT;
    xfer_pending = IMEM_READ && IMEM_BUSYWAIT;

    IF_VALID     = (count_q != '0);
    IF_PC        = IF_VALID ? pc_mem_q[rd_ptr_q]    : '0;
    IF_INSTR     = IF_VALID ? instr_mem_q[rd_ptr_q] : NOP_INSTR;
    OCCUPANCY    = count_q;

    push         = (state_q == ST_RUN) && xfer_done && !REDIRECT;
    pop          = IF_VALID && !STALL && !REDIRECT;
  end

  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    discard_pc_d = discard_pc_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q + CNT_W'(push) - CNT_W'(pop);

    if (push) begin
      wr_ptr_d   = wr_ptr_q + PTR_W'(1);
      fetch_pc_d = fetch_pc_q + XLEN'(4);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    // Completion of the abandoned request: its data is simply not pushed.
    // This wins over a same-cycle REDIRECT, which only retargets fetch_pc.
    if (state_q == ST_DISCARD && xfer_done) begin
      state_d = ST_RUN;
    end

    if (REDIRECT) begin
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      fetch_pc_d = {REDIRECT_PC[XLEN-1:2], 2'b00};
      // A request memory has already accepted cannot be cancelled; remember
      // its address so it can be seen through and thrown away.
      if (state_q == ST_RUN && xfer_pending) begin
        state_d      = ST_DISCARD;
        discard_pc_d = fetch_pc_q;
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q      <= ST_RUN;
      fetch_pc_q   <= RESET_PC;
      discard_pc_q <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      discard_pc_q <= discard_pc_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
    end
  end

  // Queue storage needs no reset: entries are only observed when count_q covers them.
  always_ff @(posedge CLK) begin
    if (push) begin
      pc_mem_q[wr_ptr_q]    <= fetch_pc_q;
      instr_mem_q[wr_ptr_q] <= IMEM_RDATA;
    end
  end

endmodule

// File: tb/tb_prefetch_fetch_unit.sv
// Testbench for prefetch_fetch_unit: directed phases push expected head PCs into a
// scoreboard queue; a negedge monitor pops and compares on every accepted instruction.
// Memory model returns addr ^ 32'hC0DE0000 so instruction words are checkable.
module tb_prefetch_fetch_unit;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic [31:0] IMEM_ADDR;
  logic        IMEM_READ;
  logic [31:0] IMEM_RDATA;
  logic        IMEM_BUSYWAIT = 1'b0;
  logic        REDIRECT = 1'b0;
  logic [31:0] REDIRECT_PC = 32'h0;
  logic        STALL = 1'b1;
  logic        IF_VALID;
  logic [31:0] IF_PC;
  logic [31:0] IF_INSTR;
  logic [2:0]  OCCUPANCY;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  prefetch_fetch_unit dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .IMEM_ADDR     (IMEM_ADDR),
    .IMEM_READ     (IMEM_READ),
    .IMEM_RDATA    (IMEM_RDATA),
    .IMEM_BUSYWAIT (IMEM_BUSYWAIT),
    .REDIRECT      (REDIRECT),
    .REDIRECT_PC   (REDIRECT_PC),
    .STALL         (STALL),
    .IF_VALID      (IF_VALID),
    .IF_PC         (IF_PC),
    .IF_INSTR      (IF_INSTR),
    .OCCUPANCY     (OCCUPANCY)
  );

  always #5 CLK = ~CLK;

  assign IMEM_RDATA = IMEM_ADDR ^ 32'hC0DE0000;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: a pop happens on the next rising edge when the head is valid and accepted.
  always @(negedge CLK) begin
    logic [31:0] e;
    if (!RESET && IF_VALID && !STALL && !REDIRECT) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pop: got pc %h expected none", IF_PC);
      end else begin
        e = exp_q.pop_front();
        chk("pop_pc", IF_PC, e);
        chk("pop_instr", IF_INSTR, e ^ 32'hC0DE0000);
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Asserts reset mid-cycle, checks the asynchronous reset state, then releases it.
  task automatic pulse_reset();
    RESET = 1'b1;
    #1;
    chk("rst_imem_read", 32'(IMEM_READ), 32'h0);
    chk("rst_if_valid",  32'(IF_VALID),  32'h0);
    chk("rst_occupancy", 32'(OCCUPANCY), 32'h0);
    chk("rst_if_pc",     IF_PC,          32'h0);
    chk("rst_if_instr",  IF_INSTR,       32'h00000013);
    @(negedge CLK);
    #2;
    RESET = 1'b0;
    #1;
    chk("first_req_read", 32'(IMEM_READ), 32'h1);
    chk("first_req_addr", IMEM_ADDR,      32'h0);
    chk("first_req_nvld", 32'(IF_VALID),  32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    // Phase A: free-running fetch from reset.
    STALL = 1'b0;
    pulse_reset();
    for (int i = 0; i < 6; i++) exp_q.push_back(32'(i * 4));
    tick();
    chk("a_first_valid", 32'(IF_VALID), 32'h1);
    chk("a_first_pc",    IF_PC,         32'h0);
    chk("a_first_occ",   32'(OCCUPANCY), 32'h1);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("a_stream_occ", 32'(OCCUPANCY), 32'h1);
    end
    STALL = 1'b1;

    // Phase B: fill under stall, then drain in order.
    pulse_reset();
    repeat (4) tick();
    chk("b_full_occ",  32'(OCCUPANCY), 32'h4);
    chk("b_full_read", 32'(IMEM_READ), 32'h0);
    tick();
    chk("b_hold_occ",  32'(OCCUPANCY), 32'h4);
    chk("b_hold_head", IF_PC,          32'h0);
    for (int i = 0; i < 4; i++) exp_q.push_back(32'(i * 4));
    STALL = 1'b0;
    repeat (4) tick();
    STALL = 1'b1;
    chk("b_next_head", IF_PC, 32'h10);

    // Phase C: busywait on 0x8.
    pulse_reset();
    repeat (2) tick();
    IMEM_BUSYWAIT = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("c_busy_addr", IMEM_ADDR,      32'h8);
      chk("c_busy_occ",  32'(OCCUPANCY), 32'h2);
      chk("c_busy_read", 32'(IMEM_READ), 32'h1);
    end
    IMEM_BUSYWAIT = 1'b0;
    tick();
    chk("c_done_occ",  32'(OCCUPANCY), 32'h3);
    chk("c_done_addr", IMEM_ADDR,      32'hC);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    exp_q.push_back(32'h8);
    STALL = 1'b0;
    repeat (3) tick();
    STALL = 1'b1;

    // Phase D: redirect to unaligned 0x103 with three entries queued.
    pulse_reset();
    repeat (3) tick();
    chk("d_pre_occ", 32'(OCCUPANCY), 32'h3);
    REDIRECT = 1'b1;
    REDIRECT_PC = 32'h103;
    tick();
    REDIRECT = 1'b0;
    chk("d_flush_occ",  32'(OCCUPANCY), 32'h0);
    chk("d_flush_addr", IMEM_ADDR,      32'h100);
    chk("d_flush_vld",  32'(IF_VALID),  32'h0);
    exp_q.push_back(32'h100);
    exp_q.push_back(32'h104);
    STALL = 1'b0;
    tick();
    chk("d_target_pc", IF_PC, 32'h100);
    repeat (2) tick();
    STALL = 1'b1;

    // Phase E: redirect while 0x10 is busy, then again while discarding.
    pulse_reset();
    repeat (4) tick();
    exp_q.push_back(32'h0);
    STALL = 1'b0;
    IMEM_BUSYWAIT = 1'b1;
    tick();
    STALL = 1'b1;
    chk("e_pend_read", 32'(IMEM_READ), 32'h1);
    chk("e_pend_addr", IMEM_ADDR,      32'h10);
    REDIRECT = 1'b1;
    REDIRECT_PC = 32'h200;
    tick();
    REDIRECT = 1'b0;
    chk("e_disc_addr", IMEM_ADDR,      32'h10);
    chk("e_disc_read", 32'(IMEM_READ), 32'h1);
    chk("e_disc_vld",  32'(IF_VALID),  32'h0);
    chk("e_disc_occ",  32'(OCCUPANCY), 32'h0);
    REDIRECT = 1'b1;
    REDIRECT_PC = 32'h300;
    tick();
    REDIRECT = 1'b0;
    chk("e_disc2_addr", IMEM_ADDR, 32'h10);
    IMEM_BUSYWAIT = 1'b0;
    tick();
    chk("e_run_addr", IMEM_ADDR,      32'h300);
    chk("e_run_occ",  32'(OCCUPANCY), 32'h0);
    exp_q.push_back(32'h300);
    exp_q.push_back(32'h304);
    STALL = 1'b0;
    tick();
    chk("e_target_pc", IF_PC, 32'h300);
    repeat (2) tick();
    STALL = 1'b1;

    // Phase F: reset asserted while a request is pending.
    repeat (2) tick();
    IMEM_BUSYWAIT = 1'b1;
    tick();
    chk("f_pend_read", 32'(IMEM_READ), 32'h1);
    chk("f_pend_occ",  32'(OCCUPANCY), 32'h3);
    #2;
    IMEM_BUSYWAIT = 1'b0;
    pulse_reset();
    tick();
    chk("f_restart_pc",  IF_PC,          32'h0);
    chk("f_restart_occ", 32'(OCCUPANCY), 32'h1);

    repeat (3) tick();
    chk("scoreboard_drain", 32'(exp_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
